dcache_ctrl: RTL and testbench



---
 rtl/dcache_ctrl_pkg.sv | 27 ++
 rtl/dcache_ctrl_if.sv | 29 ++
 rtl/dcache_array.sv | 55 +++++
 rtl/dcache_ctrl.sv | 173 +++++++++++++++++
 tb/tb_dcache_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the direct-mapped write-back data cache: FSM states,
// default geometry and address-field width helpers.
package dcache_ctrl_pkg;

  localparam int DEF_LINES = 32;
  localparam int DEF_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    FILL   = 2'd2,
    FINISH = 2'd3
  } state_e;

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int off_w(input int words);
    return $clog2(words) + 1;
  endfunction

  function automatic int tag_w(input int lines, input int words);
    return 16 - idx_w(lines) - off_w(words);
  endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// Request bus (memory stage side) and backing-memory beat port of the cache.
// master = requester/memory environment, slave = the cache controller.
interface dcache_ctrl_if;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        CacheHit;
  logic        err;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output Addr, DataIn, Rd, Wr, mem_rdata, mem_ready,
    input  DataOut, Done, Stall, CacheHit, err, mem_addr, mem_wdata, mem_rd, mem_wr
  );

  modport slave (
    input  Addr, DataIn, Rd, Wr, mem_rdata, mem_ready,
    output DataOut, Done, Stall, CacheHit, err, mem_addr, mem_wdata, mem_rd, mem_wr
  );
endinterface

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: combinational read of one line, synchronous
// word and metadata writes; reset clears only valid and dirty.
module dcache_array
  import dcache_ctrl_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS,
  localparam int IDX_W = idx_w(LINES),
  localparam int TAG_W = tag_w(LINES, WORDS),
  localparam int BW    = $clog2(WORDS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IDX_W-1:0]       idx_i,
  output logic [TAG_W-1:0]       tag_o,
  output logic                   valid_o,
  output logic                   dirty_o,
  output logic [WORDS-1:0][15:0] line_o,
  input  logic                   word_we_i,
  input  logic [BW-1:0]          word_i,
  input  logic [15:0]            wdata_i,
  input  logic                   set_dirty_i,
  input  logic                   meta_we_i,
  input  logic [TAG_W-1:0]       tag_i
);

  logic [TAG_W-1:0]       tag_q   [LINES];
  logic [WORDS-1:0][15:0] data_q  [LINES];
  logic [LINES-1:0]       valid_q;
  logic [LINES-1:0]       dirty_q;

  assign tag_o   = tag_q[idx_i];
  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign line_o  = data_q[idx_i];

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (meta_we_i) begin
        valid_q[idx_i] <= 1'b1;
        dirty_q[idx_i] <= 1'b0;
        tag_q[idx_i]   <= tag_i;
      end
      if (word_we_i && set_dirty_i) dirty_q[idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (word_we_i) data_q[idx_i][word_i] <= wdata_i;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller: hits complete in the
// request cycle; misses stall through writeback and fill beats, each held until mem_ready.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS
) (
  input  logic         clk,
  input  logic         rst,
  dcache_ctrl_if.slave bus
);

  localparam int IDX_W = idx_w(LINES);
  localparam int OFF_W = off_w(WORDS);
  localparam int TAG_W = tag_w(LINES, WORDS);
  localparam int BW    = OFF_W - 1;

  state_e           state_q, state_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [TAG_W-1:0] rtag_q, rtag_d;
  logic [IDX_W-1:0] ridx_q, ridx_d;
  logic [BW-1:0]    rword_q, rword_d;
  logic [15:0]      rdata_q, rdata_d;
  logic             rwr_q, rwr_d;

  logic [TAG_W-1:0] in_tag;
  logic [IDX_W-1:0] in_idx, cur_idx;
  logic [BW-1:0]    in_word, cur_word, word_sel;
  logic             idle, req, illegal, hit;

  logic [TAG_W-1:0]       arr_tag;
  logic                   arr_valid, arr_dirty;
  logic [WORDS-1:0][15:0] arr_line;
  logic                   word_we, set_dirty, meta_we;
  logic [15:0]            wdata;

  assign in_tag   = bus.Addr[15:IDX_W+OFF_W];
  assign in_idx   = bus.Addr[IDX_W+OFF_W-1:OFF_W];
  assign in_word  = bus.Addr[OFF_W-1:1];
  assign idle     = (state_q == IDLE);
  // Outside IDLE the live request inputs are ignored; the latched miss drives the array.
  assign cur_idx  = idle ? in_idx  : ridx_q;
  assign cur_word = idle ? in_word : rword_q;
  assign req      = bus.Rd | bus.Wr;
  assign illegal  = (bus.Rd & bus.Wr) | (req & bus.Addr[0]);
  assign hit      = arr_valid && (arr_tag == in_tag);

  dcache_array #(.LINES(LINES), .WORDS(WORDS)) u_array (
    .clk        (clk),
    .rst        (rst),
    .idx_i      (cur_idx),
    .tag_o      (arr_tag),
    .valid_o    (arr_valid),
    .dirty_o    (arr_dirty),
    .line_o     (arr_line),
    .word_we_i  (word_we),
    .word_i     (word_sel),
    .wdata_i    (wdata),
    .set_dirty_i(set_dirty),
    .meta_we_i  (meta_we),
    .tag_i      (rtag_q)
  );

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    rtag_d        = rtag_q;
    ridx_d        = ridx_q;
    rword_d       = rword_q;
    rdata_d       = rdata_q;
    rwr_d         = rwr_q;
    bus.Done      = 1'b0;
    bus.Stall     = 1'b0;
    bus.CacheHit  = 1'b0;
    bus.err       = 1'b0;
    bus.DataOut   = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    word_we       = 1'b0;
    word_sel      = cur_word;
    wdata         = bus.DataIn;
    set_dirty     = 1'b0;
    meta_we       = 1'b0;
    if (rst) begin
      unique case (state_q)
        IDLE: begin
          if (illegal) begin
            bus.err  = 1'b1;
            bus.Done = 1'b1;
          end else if (req && hit) begin
            bus.Done     = 1'b1;
            bus.CacheHit = 1'b1;
            if (bus.Rd) begin
              bus.DataOut = arr_line[in_word];
            end else begin
              word_we   = 1'b1;
              set_dirty = 1'b1;
            end
          end else if (req) begin
            bus.Stall = 1'b1;
            rtag_d    = in_tag;
            ridx_d    = in_idx;
            rword_d   = in_word;
            rdata_d   = bus.DataIn;
            rwr_d     = bus.Wr;
            beat_d    = '0;
            state_d   = (arr_valid && arr_dirty) ? WB : FILL;
          end
        end
        WB: begin
          bus.Stall     = 1'b1;
          bus.mem_wr    = 1'b1;
          bus.mem_addr  = {arr_tag, ridx_q, beat_q, 1'b0};
          bus.mem_wdata = arr_line[beat_q];
          if (bus.mem_ready) begin
            beat_d = beat_q + 1'b1;
            if (beat_q == '1) state_d = FILL;
          end
        end
        FILL: begin
          bus.Stall    = 1'b1;
          bus.mem_rd   = 1'b1;
          bus.mem_addr = {rtag_q, ridx_q, beat_q, 1'b0};
          if (bus.mem_ready) begin
            word_we  = 1'b1;
            word_sel = beat_q;
            wdata    = bus.mem_rdata;
            beat_d   = beat_q + 1'b1;
            if (beat_q == '1) begin
              meta_we = 1'b1;
              state_d = FINISH;
            end
          end
        end
        FINISH: begin
          bus.Done = 1'b1;
          if (rwr_q) begin
            word_we   = 1'b1;
            wdata     = rdata_q;
            set_dirty = 1'b1;
          end else begin
            bus.DataOut = arr_line[rword_q];
          end
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      rtag_q  <= '0;
      ridx_q  <= '0;
      rword_q <= '0;
      rdata_q <= '0;
      rwr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      rtag_q  <= rtag_d;
      ridx_q  <= ridx_d;
      rword_q <= rword_d;
      rdata_q <= rdata_d;
      rwr_q   <= rwr_d;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized bench for dcache_ctrl against a line-level cache + memory model.
module tb_dcache_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_ctrl_if bus();

  dcache_ctrl dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] pat(input int a);
    logic [31:0] t;
    t = (a * 32'h9E37) ^ 32'h5A5A;
    return t[15:0];
  endfunction

  // Backing memory with configurable wait states per beat.
  logic [15:0] mem_arr [32768];
  bit          mem_init = 1'b0;
  int          wait_n   = 0;
  int          wcnt     = 0;

  assign bus.mem_rdata = mem_arr[bus.mem_addr[15:1]];
  assign bus.mem_ready = (bus.mem_rd || bus.mem_wr) && (wcnt >= wait_n);

  always @(posedge clk) begin
    if ((bus.mem_rd || bus.mem_wr) && !bus.mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  logic [32:0] obs_q [$];
  logic [32:0] exp_q [$];
  logic        pend = 1'b0;
  logic [15:0] pend_addr;

  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 32768; i++) mem_arr[i] = pat(i);
      mem_init = 1'b1;
    end
    if (bus.mem_rd || bus.mem_wr) begin
      if (pend) check("mem_addr_hold", 64'(bus.mem_addr), 64'(pend_addr));
      if (bus.mem_ready) begin
        obs_q.push_back({bus.mem_wr, bus.mem_addr, bus.mem_wr ? bus.mem_wdata : 16'h0});
        if (bus.mem_wr) mem_arr[bus.mem_addr[15:1]] = bus.mem_wdata;
        pend = 1'b0;
      end else begin
        pend      = 1'b1;
        pend_addr = bus.mem_addr;
      end
    end else begin
      pend = 1'b0;
    end
  end

  // Reference model: cache contents and the memory image they imply.
  logic        m_valid [32];
  logic        m_dirty [32];
  logic [7:0]  m_tag   [32];
  logic [15:0] m_data  [32][4];
  logic [15:0] ref_mem [32768];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  task automatic model_req(input logic rd, input logic wr, input logic [15:0] a,
                           input logic [15:0] d, output logic e_err, output logic e_hit,
                           output logic [15:0] e_data, output int e_lat);
    logic [7:0]  ti;
    logic [4:0]  ix;
    logic [1:0]  wd;
    logic [15:0] ba;
    ti     = a[15:8];
    ix     = a[7:3];
    wd     = a[2:1];
    e_err  = (rd && wr) || ((rd || wr) && a[0]);
    e_hit  = 1'b0;
    e_data = 16'h0;
    e_lat  = 1;
    if (e_err) return;
    if (m_valid[ix] && m_tag[ix] == ti) begin
      e_hit = 1'b1;
    end else begin
      if (m_valid[ix] && m_dirty[ix]) begin
        for (int b = 0; b < 4; b++) begin
          ba = {m_tag[ix], ix, 2'(b), 1'b0};
          exp_q.push_back({1'b1, ba, m_data[ix][b]});
          ref_mem[ba[15:1]] = m_data[ix][b];
          e_lat += wait_n + 1;
        end
      end
      for (int b = 0; b < 4; b++) begin
        ba = {ti, ix, 2'(b), 1'b0};
        exp_q.push_back({1'b0, ba, 16'h0});
        m_data[ix][b] = ref_mem[ba[15:1]];
        e_lat += wait_n + 1;
      end
      m_tag[ix]   = ti;
      m_valid[ix] = 1'b1;
      m_dirty[ix] = 1'b0;
      e_lat += 1;
    end
    if (wr) begin
      m_data[ix][wd] = d;
      m_dirty[ix]    = 1'b1;
    end else begin
      e_data = m_data[ix][wd];
    end
  endtask

  task automatic do_req(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] d, input string name);
    logic        e_err, e_hit, g_err, g_hit, g_stall, done;
    logic [15:0] e_data, g_data;
    int          e_lat, cyc, stall_cnt, nb;
    obs_q.delete();
    exp_q.delete();
    model_req(rd, wr, a, d, e_err, e_hit, e_data, e_lat);
    @(posedge clk);
    #1;
    bus.Rd = rd; bus.Wr = wr; bus.Addr = a; bus.DataIn = d;
    cyc = 0; stall_cnt = 0; done = 1'b0;
    g_err = 1'b0; g_hit = 1'b0; g_stall = 1'b0; g_data = 16'h0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (bus.Done) begin
        done    = 1'b1;
        g_err   = bus.err;
        g_hit   = bus.CacheHit;
        g_data  = bus.DataOut;
        g_stall = bus.Stall;
      end else if (bus.Stall) begin
        stall_cnt++;
      end
    end
    @(posedge clk);
    #1;
    bus.Rd = 1'b0; bus.Wr = 1'b0;
    check({name, "_latency"}, 64'(cyc), 64'(e_lat));
    check({name, "_err"}, 64'(g_err), 64'(e_err));
    check({name, "_hit"}, 64'(g_hit), 64'(e_hit));
    check({name, "_stall_cycles"}, 64'(stall_cnt), 64'(e_lat - 1));
    check({name, "_stall_at_done"}, 64'(g_stall), 64'(0));
    if (rd && !e_err) check({name, "_data"}, 64'(g_data), 64'(e_data));
    check({name, "_beats"}, 64'(obs_q.size()), 64'(exp_q.size()));
    nb = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < nb; i++) check({name, "_beat"}, 64'(obs_q[i]), 64'(exp_q[i]));
  endtask

  initial begin
    logic       rd, wr;
    logic [15:0] a;
    int         r, nb, cyc;
    for (int i = 0; i < 32768; i++) ref_mem[i] = pat(i);
    model_reset();
    rst = 1'b0;
    bus.Rd = 1'b1; bus.Wr = 1'b0; bus.Addr = 16'h0010; bus.DataIn = 16'h0;
    @(negedge clk);
    check("rst_done", 64'(bus.Done), 64'(0));
    check("rst_stall", 64'(bus.Stall), 64'(0));
    check("rst_err", 64'(bus.err), 64'(0));
    check("rst_mem_rd", 64'(bus.mem_rd), 64'(0));
    check("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
    check("rst_dataout", 64'(bus.DataOut), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.Rd = 1'b0;

    wait_n = 0;
    do_req(1'b1, 1'b0, 16'h0010, 16'h0000, "clean_miss");
    do_req(1'b0, 1'b1, 16'h0012, 16'hBEEF, "store_hit");
    do_req(1'b1, 1'b0, 16'h0012, 16'h0000, "load_hit");
    do_req(1'b1, 1'b0, 16'h0112, 16'h0000, "dirty_miss");
    wait_n = 3;
    do_req(1'b1, 1'b0, 16'h0020, 16'h0000, "slow_miss");
    wait_n = 0;
    do_req(1'b1, 1'b1, 16'h0112, 16'h1234, "ill_rdwr");
    do_req(1'b1, 1'b0, 16'h0111, 16'h0000, "ill_odd");
    do_req(1'b0, 1'b1, 16'h0113, 16'h5555, "ill_odd_wr");
    do_req(1'b1, 1'b0, 16'h0112, 16'h0000, "reread");

    // Reset in the middle of a fill, on beat 2.
    obs_q.delete();
    @(posedge clk);
    #1;
    bus.Rd = 1'b1; bus.Addr = 16'h0438;
    nb = 0; cyc = 0;
    while (nb < 2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_rd && bus.mem_ready) nb++;
    end
    check("abort_pre_beats", 64'(nb), 64'(2));
    @(posedge clk);
    #1;
    check("abort_beat2_addr", 64'(bus.mem_addr), 64'(16'h043C));
    check("abort_beat2_rd", 64'(bus.mem_rd), 64'(1));
    rst = 1'b0;
    #1;
    check("abort_mem_rd", 64'(bus.mem_rd), 64'(0));
    check("abort_stall", 64'(bus.Stall), 64'(0));
    check("abort_done", 64'(bus.Done), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.Rd = 1'b0;
    model_reset();
    do_req(1'b1, 1'b0, 16'h0438, 16'h0000, "refetch");

    for (int n = 0; n < 150; n++) begin
      wait_n = $urandom_range(0, 2);
      a = {6'h0, 2'($urandom_range(0, 3)), 3'h0, 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 1'b0};
      r = $urandom_range(0, 15);
      if (r == 0) begin
        rd = 1'b1; wr = 1'b1;
      end else if (r == 1) begin
        rd = 1'b1; wr = 1'b0; a[0] = 1'b1;
      end else begin
        rd = 1'($urandom_range(0, 1)); wr = ~rd;
      end
      do_req(rd, wr, a, 16'($urandom()), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
